// File: rtl/fp16_add_pipe.sv
// Two-stage pipelined IEEE-754 binary16 adder, round-to-nearest-even.
// Define FP16_ADD_SUBNORMAL_EN for subnormal support; the default build flushes subnormals to zero.
module fp16_add_pipe #(
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] result
);

  localparam int unsigned SIG_W = 11;
  localparam int unsigned ALN_W = 14;
  localparam int unsigned SUM_W = 15;
  localparam int unsigned EXP_W = 6;

  if (PIPE_STAGES != 2) begin : g_unsupported
    $error("fp16_add_pipe supports only PIPE_STAGES == 2");
  end

  function automatic logic [3:0] lzc14(input logic [ALN_W-1:0] v);
    lzc14 = 4'd14;
    for (int i = 0; i < int'(ALN_W); i++) begin
      if (v[i]) lzc14 = 4'(13 - i);
    end
  endfunction

  // Stage 1: classify, order by magnitude, align the smaller significand
  logic              b_big;
  logic [15:0]       big, sml;
  logic [SIG_W-1:0]  sig_big, sig_sml;
  logic [4:0]        exp_big, exp_sml, diff;
  logic [26:0]       wide;
  logic              a_nan, b_nan, a_inf, b_inf;

  logic              v1_q, nan1_q, inf1_q, inf_sign1_q, sign1_q, sub1_q;
  logic              nan1_d, inf1_d, inf_sign1_d;
  logic [4:0]        exp1_q;
  logic [SIG_W-1:0]  sig_l1_q;
  logic [ALN_W-1:0]  sig_s1_q, sig_s1_d;

  always_comb begin
    b_big   = b[14:0] > a[14:0];
    big     = b_big ? b : a;
    sml     = b_big ? a : b;
`ifdef FP16_ADD_SUBNORMAL_EN
    sig_big = {(big[14:10] != 5'd0), big[9:0]};
    sig_sml = {(sml[14:10] != 5'd0), sml[9:0]};
`else
    sig_big = (big[14:10] != 5'd0) ? {1'b1, big[9:0]} : 11'd0;
    sig_sml = (sml[14:10] != 5'd0) ? {1'b1, sml[9:0]} : 11'd0;
`endif
    exp_big = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
    exp_sml = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
    diff    = exp_big - exp_sml;
    wide    = {sig_sml, 16'd0} >> diff;
    sig_s1_d = (diff >= 5'd13) ? {13'd0, |sig_sml} : {wide[26:14], |wide[13:0]};

    a_nan = (&a[14:10]) & (|a[9:0]);
    b_nan = (&b[14:10]) & (|b[9:0]);
    a_inf = (&a[14:10]) & ~(|a[9:0]);
    b_inf = (&b[14:10]) & ~(|b[9:0]);
    nan1_d      = a_nan | b_nan | (a_inf & b_inf & (a[15] ^ b[15]));
    inf1_d      = a_inf | b_inf;
    inf_sign1_d = a_inf ? a[15] : b[15];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      nan1_q      <= 1'b0;
      inf1_q      <= 1'b0;
      inf_sign1_q <= 1'b0;
      sign1_q     <= 1'b0;
      sub1_q      <= 1'b0;
      exp1_q      <= 5'd0;
      sig_l1_q    <= '0;
      sig_s1_q    <= '0;
    end else begin
      v1_q        <= in_valid;
      nan1_q      <= nan1_d;
      inf1_q      <= inf1_d;
      inf_sign1_q <= inf_sign1_d;
      sign1_q     <= big[15];
      sub1_q      <= a[15] ^ b[15];
      exp1_q      <= exp_big;
      sig_l1_q    <= sig_big;
      sig_s1_q    <= sig_s1_d;
    end
  end

  // Stage 2: add/subtract, normalize, round, pack
  logic [SUM_W-1:0] sum, mag;
  logic [ALN_W-1:0] m;
  logic [3:0]       lz;
  logic [4:0]       lim, shamt;
  logic [EXP_W-1:0] exp_w;
  logic             rup;
  logic [15:0]      res_d;

  logic             out_valid_q;
  logic [15:0]      result_q;

  always_comb begin
    sum   = sub1_q ? ({1'b0, sig_l1_q, 3'b000} - {1'b0, sig_s1_q})
                   : ({1'b0, sig_l1_q, 3'b000} + {1'b0, sig_s1_q});
    lz    = lzc14(sum[13:0]);
    // Left shift never drops the exponent below 1; what remains is subnormal.
    lim   = exp1_q - 5'd1;
    shamt = ({1'b0, lz} > lim) ? lim : {1'b0, lz};
    if (sum[14]) begin
      m     = {sum[14:2], sum[1] | sum[0]};
      exp_w = {1'b0, exp1_q} + 6'd1;
    end else begin
      m     = sum[13:0] << shamt;
      exp_w = {1'b0, exp1_q} - {1'b0, shamt};
    end
    rup = m[2] & (m[1] | m[0] | m[3]);
    // Rounding carry ripples into the exponent field, renormalizing for free.
    mag = {(m[13] ? exp_w[4:0] : 5'd0), m[12:3]} + {14'd0, rup};

    res_d = {sign1_q, mag};
    if (nan1_q) begin
      res_d = 16'h7E00;
    end else if (inf1_q) begin
      res_d = {inf_sign1_q, 15'h7C00};
    end else if (sum == 15'd0) begin
      res_d = {sign1_q & ~sub1_q, 15'd0};
    end else if (exp_w >= 6'd31) begin
      res_d = {sign1_q, 15'h7C00};
`ifndef FP16_ADD_SUBNORMAL_EN
    end else if (mag[14:10] == 5'd0) begin
      res_d = {sign1_q, 15'd0};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) result_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fp16_add_pipe.sv
// Directed self-checking bench for fp16_add_pipe: latency, rounding, specials, throughput, reset.
module tb_fp16_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  logic [15:0] va [10] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                           16'h3800, 16'hC000, 16'h4500, 16'h0000, 16'h8000};
  logic [15:0] vb [10] = '{16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'hBC00,
                           16'h3800, 16'h3C00, 16'h4500, 16'h3C00, 16'h8000};
  logic [15:0] ve [10] = '{16'h4000, 16'h4200, 16'h4400, 16'h4400, 16'h4200,
                           16'h3C00, 16'hBC00, 16'h4900, 16'h3C00, 16'h8000};

  fp16_add_pipe #(.PIPE_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] e);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 16'(out_valid), 16'h0001);
    check(tag, result, e);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    #12;
    check("reset_valid", 16'(out_valid), 16'h0000);
    check("reset_result", result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    single("one_plus_one",   16'h3C00, 16'h3C00, 16'h4000);
    single("one_plus_two",   16'h3C00, 16'h4000, 16'h4200);
    single("cancel",         16'h3C00, 16'hBC00, 16'h0000);
    single("round_up",       16'h3C00, 16'h1400, 16'h3C01);
    single("tie_even_down",  16'h3C00, 16'h1000, 16'h3C00);
    single("tie_even_up",    16'h3C01, 16'h1000, 16'h3C02);
    single("overflow",       16'h7BFF, 16'h7BFF, 16'h7C00);
    single("inf_minus_inf",  16'h7C00, 16'hFC00, 16'h7E00);
    single("nan_in",         16'h7E00, 16'h3C00, 16'h7E00);
    single("neg_inf_finite", 16'hFC00, 16'h4000, 16'hFC00);
    single("neg_zeros",      16'h8000, 16'h8000, 16'h8000);
`ifdef FP16_ADD_SUBNORMAL_EN
    single("subnormal_sum",  16'h0001, 16'h0001, 16'h0002);
    single("underflow_neg",  16'h8401, 16'h0400, 16'h8001);
`else
    single("subnormal_sum",  16'h0001, 16'h0001, 16'h0000);
    single("underflow_neg",  16'h8401, 16'h0400, 16'h8000);
`endif

    // Idle input: valid drops, result holds the last value
    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_valid", 16'(out_valid), 16'h0000);
`ifdef FP16_ADD_SUBNORMAL_EN
    check("idle_hold", result, 16'h8001);
`else
    check("idle_hold", result, 16'h8000);
`endif

    // Ten back-to-back operations
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("b2b%0d_valid", k - 2), 16'(out_valid), 16'h0001);
        check($sformatf("b2b%0d", k - 2), result, ve[k - 2]);
      end
      if (k < 10) begin
        a = va[k]; b = vb[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_drain_valid", 16'(out_valid), 16'h0000);

    // Asynchronous reset with operations in flight
    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h4000; b = 16'h4000;
    #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("async_rst_valid", 16'(out_valid), 16'h0000);
    check("async_rst_result", result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_valid", k), 16'(out_valid), 16'h0000);
      check($sformatf("post_rst%0d_result", k), result, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
